// File: rtl/tx_payload_crc_ble_if.sv
// Bundles the start/config, payload input handshake and serial output
// of tx_payload_crc_ble.
//   slave  : the CRC appender (drives ready_out, data_out, valid_out,
//            busy, done, crc_out)
//   master : the packet formatter side (drives start, n_bits, uap_dci,
//            valid_in, data_bit, err_inject)
interface tx_payload_crc_ble_if;
  logic        start;
  logic [15:0] n_bits;
  logic [7:0]  uap_dci;
  logic        valid_in;
  logic        data_bit;
  logic        err_inject;
  logic        ready_out;
  logic        data_out;
  logic        valid_out;
  logic        busy;
  logic        done;
  logic [15:0] crc_out;

  modport slave (
    input  start, n_bits, uap_dci, valid_in, data_bit, err_inject,
    output ready_out, data_out, valid_out, busy, done, crc_out
  );

  modport master (
    output start, n_bits, uap_dci, valid_in, data_bit, err_inject,
    input  ready_out, data_out, valid_out, busy, done, crc_out
  );
endinterface

// File: rtl/tx_payload_crc_ble.sv
// BLE TX payload CRC appender. Forwards each accepted payload bit one cycle
// later, then appends the 16-bit payload CRC (preloaded from UAP/DCI)
// MSB-first with no gap.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-low reset
//   bus   : tx_payload_crc_ble_if.slave
//           in : start, n_bits, uap_dci, valid_in, data_bit, err_inject
//           out: ready_out, data_out, valid_out, busy, done, crc_out
//
// Build option: TX_CRC_ERR_INJECT_EN -- when defined, err_inject sampled on
// entry to the CRC field inverts bit 0 of the transmitted CRC and crc_out.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start (busy may still be high on the done cycle)
// S_PAYLOAD | accepting payload bits, updating the CRC
// S_CRC     | shifting crc_out MSB-first onto data_out
module tx_payload_crc_ble #(
  parameter int          Length = 16,
  parameter logic [15:0] POLY   = 16'h1021
) (
  input logic                 clk,
  input logic                 reset,
  tx_payload_crc_ble_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC} state_t;

  state_t            state, state_nxt;
  logic [Length-1:0] crc, crc_nxt, crc_out_r;
  logic [15:0]       cnt, n_lat;
  logic [3:0]        crc_idx;
  logic              busy_r, data_out_r, valid_out_r, done_r;
  logic              ready, accept, last_bit, start_ok, fb, inj;
  logic [Length-1:0] inj_mask, preload;

`ifdef TX_CRC_ERR_INJECT_EN
  assign inj = bus.err_inject;
`else
  assign inj = 1'b0;
`endif

  assign inj_mask = {{(Length-1){1'b0}}, inj};
  assign preload  = {8'h00, bus.uap_dci};

  // busy stays high through the done cycle, so a start landing on the done
  // cycle is ignored and the earliest restart is the cycle after done.
  assign start_ok = bus.start && !busy_r && (state == S_IDLE);
  assign ready    = (state == S_PAYLOAD) && (cnt < n_lat);
  assign accept   = ready && bus.valid_in;
  assign last_bit = accept && (cnt == n_lat - 16'd1);

  assign fb      = bus.data_bit ^ crc[Length-1];
  assign crc_nxt = {crc[Length-2:0], 1'b0} ^ (fb ? POLY : '0);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = (bus.n_bits != 16'd0) ? S_PAYLOAD : S_CRC;
      end
      S_PAYLOAD: begin
        if (last_bit) state_nxt = S_CRC;
      end
      S_CRC: begin
        if (crc_idx == 4'd15) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      crc         <= '0;
      crc_out_r   <= '0;
      cnt         <= '0;
      n_lat       <= '0;
      crc_idx     <= '0;
      busy_r      <= 1'b0;
      data_out_r  <= 1'b0;
      valid_out_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          valid_out_r <= 1'b0;
          data_out_r  <= 1'b0;
          if (done_r) busy_r <= 1'b0;
          if (start_ok) begin
            busy_r <= 1'b1;
            n_lat  <= bus.n_bits;
            crc    <= preload;
            cnt    <= '0;
            // Zero-length frame: the CRC is just the preload, whose MSB is
            // always 0, so bit 15 goes out right away and the shifter
            // resumes at bit 14.
            if (bus.n_bits == 16'd0) begin
              crc_out_r   <= preload ^ inj_mask;
              data_out_r  <= 1'b0;
              valid_out_r <= 1'b1;
              crc_idx     <= 4'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            data_out_r  <= bus.data_bit;
            valid_out_r <= 1'b1;
            crc         <= crc_nxt;
            cnt         <= cnt + 16'd1;
            if (last_bit) begin
              crc_out_r <= crc_nxt ^ inj_mask;
              crc_idx   <= 4'd0;
            end
          end else begin
            valid_out_r <= 1'b0;
          end
        end
        S_CRC: begin
          data_out_r  <= crc_out_r[4'd15 - crc_idx];
          valid_out_r <= 1'b1;
          done_r      <= (crc_idx == 4'd15);
          crc_idx     <= crc_idx + 4'd1;
        end
        default: begin
          valid_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out = ready;
  assign bus.data_out  = data_out_r;
  assign bus.valid_out = valid_out_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.crc_out   = crc_out_r;

endmodule

// File: tb/tb_tx_payload_crc_ble.sv
// Scoreboard bench for tx_payload_crc_ble: the driver pushes every expected
// output bit (payload then CRC) into a queue; a negedge monitor pops and
// compares whenever valid_out is high. The reference CRC is computed as a
// polynomial remainder (preload*x^n + M*x^16) mod G over a bit array.
module tb_tx_payload_crc_ble;

  typedef struct {
    logic        b;
    bit          is_crc;
    bit          last;
    logic [15:0] crc;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   crc_seen;
  bit   must_follow;
  exp_t exp_q[$];
  bit   pl[$];

  tx_payload_crc_ble_if bus();

  tx_payload_crc_ble dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [7:0] uap, input int n, input bit p[$]);
    bit          dv[];
    logic [15:0] g;
    logic [15:0] init;
    logic [15:0] r;
    g    = 16'h1021;
    init = {8'h00, uap};
    dv   = new[n + 16];
    for (int k = 0; k < n + 16; k++) dv[k] = 1'b0;
    for (int j = 0; j < 16; j++) dv[n + j] ^= init[j];
    for (int i = 0; i < n; i++) dv[n - 1 - i + 16] ^= p[i];
    for (int k = n + 15; k >= 16; k--) begin
      if (dv[k]) begin
        dv[k] = 1'b0;
        for (int j = 0; j < 16; j++) dv[k - 16 + j] ^= g[j];
      end
    end
    for (int j = 0; j < 16; j++) r[j] = dv[j];
    return r;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk1("unexpected_output", bus.valid_out, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk1("data_out", bus.data_out, e.b);
        chk1("done", bus.done, e.last);
        if (e.last) chk16("crc_out", bus.crc_out, e.crc);
        if (e.is_crc) crc_seen++;
        must_follow = !e.last && (exp_q.size() > 0) && exp_q[0].is_crc;
      end
    end else begin
      if (must_follow) chk1("crc_gap_valid_out", bus.valid_out, 1'b1);
      must_follow = 1'b0;
      if (bus.done === 1'b1) chk1("done_without_valid", bus.done, 1'b0);
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk1("frame_complete_timeout", ok, 1'b1);
  endtask

  task automatic fill_random(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input int n, input logic [7:0] uap, input int stall_pct,
                            input bit strays, input bit inj, input bit wait_end);
    logic [15:0] c;
    exp_t        e;
    bit          inj_eff;
`ifdef TX_CRC_ERR_INJECT_EN
    inj_eff = inj;
`else
    inj_eff = 1'b0;
`endif
    c = ref_crc(uap, n, pl) ^ {15'd0, inj_eff};
    for (int i = 0; i < n; i++) begin
      e.b = pl[i]; e.is_crc = 1'b0; e.last = 1'b0; e.crc = c;
      exp_q.push_back(e);
    end
    for (int i = 15; i >= 0; i--) begin
      e.b = c[i]; e.is_crc = 1'b1; e.last = (i == 0); e.crc = c;
      exp_q.push_back(e);
    end
    crc_seen = 0;
    bus.start      = 1'b1;
    bus.n_bits     = 16'(n);
    bus.uap_dci    = uap;
    bus.err_inject = inj;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk1("busy_after_start", bus.busy, 1'b1);
    chk1("ready_after_start", bus.ready_out, n != 0);
    if (n == 0) chk1("zero_len_first_crc_bit", bus.valid_out, 1'b1);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(0, 99)) < stall_pct) begin
        bus.valid_in = 1'b0;
        @(posedge clk); #1;
      end
      if (strays && i == n / 2) begin
        bus.start   = 1'b1;
        bus.n_bits  = 16'd3;
        bus.uap_dci = ~uap;
      end
      bus.valid_in = 1'b1;
      bus.data_bit = pl[i];
      chk1("ready_in_payload", bus.ready_out, 1'b1);
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.valid_in = 1'b0;
    end
    if (strays) begin
      for (int k = 0; k < 3; k++) begin
        bus.valid_in = 1'b1;
        bus.data_bit = 1'($urandom_range(0, 1));
        chk1("ready_after_last", bus.ready_out, 1'b0);
        @(posedge clk); #1;
      end
      bus.valid_in = 1'b0;
    end
    if (wait_end) wait_idle();
  endtask

  initial begin
    bit reached;
    errors = 0; checks = 0; crc_seen = 0; must_follow = 1'b0;
    reset = 1'b0;
    bus.start = 1'b0; bus.n_bits = 16'd0; bus.uap_dci = 8'h00;
    bus.valid_in = 1'b0; bus.data_bit = 1'b0; bus.err_inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_data_out", bus.data_out, 1'b0);
    chk1("rst_valid_out", bus.valid_out, 1'b0);
    chk1("rst_ready_out", bus.ready_out, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk16("rst_crc_out", bus.crc_out, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed frames from the test plan
    pl.delete();
    send_frame(0, 8'h47, 0, 1'b0, 1'b0, 1'b1);
    chk16("zero_len_crc", bus.crc_out, 16'h0047);
    pl.delete(); pl.push_back(1'b1);
    send_frame(1, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    chk16("single_one_crc", bus.crc_out, 16'h1021);
    pl.delete(); pl.push_back(1'b0);
    send_frame(1, 8'h80, 0, 1'b0, 1'b0, 1'b1);
    chk16("single_zero_crc", bus.crc_out, 16'h0100);

    // Same 8-bit payload, clean and with stalls / stray inputs
    fill_random(8);
    send_frame(8, 8'h5A, 0, 1'b0, 1'b0, 1'b1);
    send_frame(8, 8'h5A, 40, 1'b1, 1'b0, 1'b1);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(0, 40));
      fill_random(n);
      send_frame(n, 8'($urandom_range(0, 255)), 25, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);
    end
    fill_random(100);
    send_frame(100, 8'($urandom_range(0, 255)), 20, 1'b0, 1'b0, 1'b1);
    fill_random(100);
    send_frame(100, 8'h3C, 10, 1'b0, 1'b1, 1'b1);

    // Reset during the 5th CRC bit
    fill_random(4);
    send_frame(4, 8'hC3, 0, 1'b0, 1'b0, 1'b0);
    reached = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (crc_seen >= 5) begin
        reached = 1'b1;
        break;
      end
    end
    chk1("reach_fifth_crc_bit", reached, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    must_follow = 1'b0;
    chk1("midrst_data_out", bus.data_out, 1'b0);
    chk1("midrst_valid_out", bus.valid_out, 1'b0);
    chk1("midrst_ready_out", bus.ready_out, 1'b0);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_done", bus.done, 1'b0);
    chk16("midrst_crc_out", bus.crc_out, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;
    fill_random(12);
    send_frame(12, 8'h91, 15, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
